// File: rtl/wb_unit_pkg.sv
// ----------------------------------------------------------------------------
// wb_unit_pkg
// Shared definitions for the writeback unit:
//   - RISC-V load funct3 encodings (F3_LB .. F3_LHU)
//   - register index width and datapath width
//   - the load-buffer entry {rd, data}
//   - ld_extend(): byte/halfword selection and sign/zero extension of a raw,
//     aligned memory word.
// Optional feature macro used by the files that import this package:
// WB_FWD_EN.
// ----------------------------------------------------------------------------
package wb_unit_pkg;

    localparam int XLEN      = 32;
    localparam int REG_IDX_W = 5;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // One buffered load result, already extended.
    typedef struct packed {
        logic [REG_IDX_W-1:0] rd;
        logic [XLEN-1:0]      data;
    } wb_entry_t;

    localparam int WB_ENTRY_W = $bits(wb_entry_t);

    // Select the addressed byte/halfword of an aligned word and extend it.
    // addr_lo[0] is irrelevant for halfwords and addr_lo is irrelevant for
    // words. The reserved encodings (011, 110, 111) fall through to the
    // full-word case.
    function automatic logic [XLEN-1:0] ld_extend(
        input logic [2:0]      funct3,
        input logic [1:0]      addr_lo,
        input logic [XLEN-1:0] word
    );
        logic [7:0]      byte_val;
        logic [15:0]     half_val;
        logic [XLEN-1:0] result;

        case (addr_lo)
            2'd0:    byte_val = word[7:0];
            2'd1:    byte_val = word[15:8];
            2'd2:    byte_val = word[23:16];
            default: byte_val = word[31:24];
        endcase

        half_val = addr_lo[1] ? word[31:16] : word[15:0];

        case (funct3)
            F3_LB:   result = {{24{byte_val[7]}}, byte_val};
            F3_LH:   result = {{16{half_val[15]}}, half_val};
            F3_LBU:  result = {24'h0, byte_val};
            F3_LHU:  result = {16'h0, half_val};
            default: result = word;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/wb_unit_if.sv
// ----------------------------------------------------------------------------
// wb_unit_if
// Bundles every non-clock/reset signal of the writeback unit.
//   ALU path     : alu_valid, alu_rd, alu_data (no backpressure)
//   Load issue   : ld_issue, ld_issue_rd
//   Load response: mem_rsp_valid/ready, mem_rsp_rd, mem_rsp_funct3,
//                  mem_rsp_addr_lo, mem_rsp_data
//   Decode query : query_rs1, query_rs2, query_rd -> stall
//   Regfile port : rd_we, writeReg, writeData
//   WB_FWD_EN    : adds fwd_rs1_hit, fwd_rs2_hit, fwd_data
// Modports: slave = the writeback unit, master = the surrounding pipeline.
//
// Handshake: a load response transfers on a rising clock edge where
// mem_rsp_valid and mem_rsp_ready are both 1. While valid is high and the
// transfer has not happened, the producer holds valid and all mem_rsp_*
// payload stable. ready does not depend on valid.
// ----------------------------------------------------------------------------
interface wb_unit_if #(
    parameter int XLEN = 32
);

    logic            alu_valid;
    logic [4:0]      alu_rd;
    logic [XLEN-1:0] alu_data;

    logic            ld_issue;
    logic [4:0]      ld_issue_rd;

    logic            mem_rsp_valid;
    logic            mem_rsp_ready;
    logic [4:0]      mem_rsp_rd;
    logic [2:0]      mem_rsp_funct3;
    logic [1:0]      mem_rsp_addr_lo;
    logic [XLEN-1:0] mem_rsp_data;

    logic [4:0]      query_rs1;
    logic [4:0]      query_rs2;
    logic [4:0]      query_rd;
    logic            stall;

    logic            rd_we;
    logic [4:0]      writeReg;
    logic [XLEN-1:0] writeData;

`ifdef WB_FWD_EN
    logic            fwd_rs1_hit;
    logic            fwd_rs2_hit;
    logic [XLEN-1:0] fwd_data;
`endif

    modport slave (
        input  alu_valid, alu_rd, alu_data,
        input  ld_issue, ld_issue_rd,
        input  mem_rsp_valid, mem_rsp_rd, mem_rsp_funct3, mem_rsp_addr_lo, mem_rsp_data,
        output mem_rsp_ready,
        input  query_rs1, query_rs2, query_rd,
        output stall,
`ifdef WB_FWD_EN
        output fwd_rs1_hit, fwd_rs2_hit, fwd_data,
`endif
        output rd_we, writeReg, writeData
    );

    modport master (
        output alu_valid, alu_rd, alu_data,
        output ld_issue, ld_issue_rd,
        output mem_rsp_valid, mem_rsp_rd, mem_rsp_funct3, mem_rsp_addr_lo, mem_rsp_data,
        input  mem_rsp_ready,
        output query_rs1, query_rs2, query_rd,
        input  stall,
`ifdef WB_FWD_EN
        input  fwd_rs1_hit, fwd_rs2_hit, fwd_data,
`endif
        input  rd_we, writeReg, writeData
    );

endinterface

// File: rtl/wb_unit_ld_fifo.sv
// ----------------------------------------------------------------------------
// wb_ld_fifo
// Synchronous FIFO with asynchronous active-high reset.
//   clk, rst     : clock, async reset (empties the FIFO)
//   push, din    : write din when push and not full
//   pop,  dout   : dout is the head entry; pop advances it when not empty
//   full, empty  : occupancy flags
// DEPTH must be a power of two (>= 2) so pointers wrap naturally.
// ----------------------------------------------------------------------------
module wb_ld_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 37
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);
    assign dout  = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: only entries between rd_ptr and wr_ptr are read.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

endmodule

// File: rtl/wb_unit.sv
// ----------------------------------------------------------------------------
// wb_unit
// Writeback unit driving the register file write port. Single-cycle ALU
// results have strict priority; load responses are extended on arrival and
// buffered in wb_ld_fifo until a cycle without an ALU result. A pending-load
// bit per register tells decode when to stall.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : wb_unit_if.slave (ALU, load issue, load response with
//              valid/ready, decode query/stall, registered regfile port)
// Parameters: LD_FIFO_DEPTH (power of two, >= 2), XLEN (must match the
// package XLEN, 32).
// Optional feature macro WB_FWD_EN: adds fwd_rs1_hit/fwd_rs2_hit/fwd_data
// forwarding from the registered write port, and a forwarded source no
// longer stalls on its pending bit.
// ----------------------------------------------------------------------------
module wb_unit #(
    parameter int LD_FIFO_DEPTH = 2,
    parameter int XLEN          = 32
) (
    input  logic     clk,
    input  logic     rst,
    wb_unit_if.slave bus
);

    import wb_unit_pkg::*;

    wb_entry_t         push_entry;
    wb_entry_t         head_entry;
    logic [WB_ENTRY_W-1:0] head_raw;
    logic              fifo_push;
    logic              fifo_pop;
    logic              fifo_full;
    logic              fifo_empty;

    logic              rd_we_q;
    logic [4:0]        write_reg_q;
    logic [XLEN-1:0]   write_data_q;
    logic              from_ld_q;   // current output word came from the load path

    logic [31:0]       pending_q;
    logic [31:0]       pending_nxt;

    // ---------------------------------------------------------------- load path
    assign bus.mem_rsp_ready = !fifo_full;
    assign fifo_push         = bus.mem_rsp_valid && !fifo_full;
    // The FIFO head is only consumed in cycles the ALU leaves idle.
    assign fifo_pop          = !bus.alu_valid && !fifo_empty;

    always_comb begin
        push_entry      = '0;
        push_entry.rd   = bus.mem_rsp_rd;
        push_entry.data = ld_extend(bus.mem_rsp_funct3, bus.mem_rsp_addr_lo, bus.mem_rsp_data);
    end

    assign head_entry = wb_entry_t'(head_raw);

    wb_ld_fifo #(
        .DEPTH (LD_FIFO_DEPTH),
        .WIDTH (WB_ENTRY_W)
    ) u_ld_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .din   (push_entry),
        .pop   (fifo_pop),
        .dout  (head_raw),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // ------------------------------------------------------- output register
    // Writes to x0 are still consumed but never enable the regfile.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_we_q      <= 1'b0;
            write_reg_q  <= '0;
            write_data_q <= '0;
            from_ld_q    <= 1'b0;
        end else if (bus.alu_valid) begin
            rd_we_q      <= (bus.alu_rd != 5'd0);
            write_reg_q  <= bus.alu_rd;
            write_data_q <= bus.alu_data;
            from_ld_q    <= 1'b0;
        end else if (!fifo_empty) begin
            rd_we_q      <= (head_entry.rd != 5'd0);
            write_reg_q  <= head_entry.rd;
            write_data_q <= head_entry.data;
            from_ld_q    <= 1'b1;
        end else begin
            rd_we_q      <= 1'b0;
            from_ld_q    <= 1'b0;
        end
    end

    assign bus.rd_we     = rd_we_q;
    assign bus.writeReg  = write_reg_q;
    assign bus.writeData = write_data_q;

    // ------------------------------------------------------------ scoreboard
    // The pending bit is cleared on the edge the regfile captures the load
    // result. A new issue to the same register on that edge wins.
    always_comb begin
        pending_nxt = pending_q;
        if (rd_we_q && from_ld_q) begin
            pending_nxt[write_reg_q] = 1'b0;
        end
        if (bus.ld_issue && (bus.ld_issue_rd != 5'd0)) begin
            pending_nxt[bus.ld_issue_rd] = 1'b1;
        end
        pending_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_nxt;
        end
    end

`ifdef WB_FWD_EN
    logic hit_rs1;
    logic hit_rs2;

    assign hit_rs1 = rd_we_q && (write_reg_q != 5'd0) && (write_reg_q == bus.query_rs1);
    assign hit_rs2 = rd_we_q && (write_reg_q != 5'd0) && (write_reg_q == bus.query_rs2);

    assign bus.fwd_rs1_hit = hit_rs1;
    assign bus.fwd_rs2_hit = hit_rs2;
    assign bus.fwd_data    = write_data_q;

    // A source served by forwarding does not need to wait for the regfile.
    assign bus.stall = (pending_q[bus.query_rs1] && !hit_rs1)
                     | (pending_q[bus.query_rs2] && !hit_rs2)
                     |  pending_q[bus.query_rd];
`else
    assign bus.stall = pending_q[bus.query_rs1]
                     | pending_q[bus.query_rs2]
                     | pending_q[bus.query_rd];
`endif

endmodule

// File: doc/wb_unit.md
Name: wb_unit

Overview:
Writeback unit that drives the register file write port (rd_we / writeReg / writeData).
- Merges single-cycle ALU results with out-of-order-latency load responses from data memory.
- Performs RISC-V load sign/zero extension.
- Keeps a pending-load scoreboard that tells decode when to stall on RAW/WAW hazards.
- Sits between execute/memory and the regfile.

Parameters:
LD_FIFO_DEPTH, 2, load-response buffer entries; power of 2, >=2
XLEN, 32, datapath width

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
alu_valid  in  1  ALU result valid this cycle; no backpressure
alu_rd  in  5  ALU destination register
alu_data  in  32  ALU result
ld_issue  in  1  load issued to memory this cycle
ld_issue_rd  in  5  destination of issued load
mem_rsp_valid  in  1  load response valid
mem_rsp_ready  out  1  response accepted when valid&ready
mem_rsp_rd  in  5  response destination register
mem_rsp_funct3  in  3  load type
mem_rsp_addr_lo  in  2  byte address bits [1:0]
mem_rsp_data  in  32  raw aligned memory word
query_rs1  in  5  decode source 1
query_rs2  in  5  decode source 2
query_rd  in  5  decode destination
stall  out  1  decode must hold
rd_we  out  1  regfile write enable (registered)
writeReg  out  5  regfile write index (registered)
writeData  out  32  regfile write data (registered)

Behaviour:
Reset:
- rd_we=0, writeReg=0, writeData=0.
- FIFO empty; mem_rsp_ready=1 after reset deasserts.
- Scoreboard all zero; stall=0.
- Reset mid-operation discards buffered responses and pending bits.

Load response path:
- mem_rsp_ready = !fifo_full.
- An accepted response is extended at push and stored as {rd, data}.
- Extension: 000 LB sign byte[addr_lo]; 001 LH sign half[addr_lo[1]]; 010 LW word; 100 LBU zero byte; 101 LHU zero half.
- Reserved funct3 (011, 110, 111) are treated as LW.
- addr_lo[0] is ignored for halfwords; addr_lo is ignored for words.

Arbitration (each cycle):
- If alu_valid: output regs load {alu_rd, alu_data}; ALU has strict priority.
- Else if FIFO non-empty: pop head into output regs.
- Else rd_we=0.
- Latency: ALU 1 cycle. Load is 1 cycle push-to-pop minimum (push at edge N, earliest output at edge N+1).
- Push and pop in the same cycle are legal when full: ready stays 0 that cycle; freed space is visible next cycle.

x0 handling: any selected entry with rd=0 yields rd_we=0 (still popped).

Scoreboard:
- 32-bit pending vector; bit 0 is never set.
- Set: ld_issue && ld_issue_rd!=0 sets pending[ld_issue_rd] at the edge.
- Clear: at the edge where rd_we=1 and the output came from the load path, clear pending[writeReg]. The regfile captures at that same edge.
- Same-edge set and clear of the same index: set wins.
- stall = pending[query_rs1] | pending[query_rs2] | pending[query_rd] (combinational). Index 0 never stalls.

Design constraints:
- Decode blocks WAW via stall, so a single pending bit per register suffices.
- At most one outstanding load per rd.
- Occupancy counter width is clog2(LD_FIFO_DEPTH)+1. Pointers wrap modulo depth.

Optional Feature:
Macro WB_FWD_EN.
- Defined: adds outputs fwd_rs1_hit, fwd_rs2_hit (1 bit) and fwd_data (32).
  - hit = rd_we && writeReg!=0 && writeReg==query_rsN; fwd_data = writeData.
  - stall ignores pending[query_rsN] when that source's hit is asserted.
- Undefined: ports absent; stall exactly as above.

Decomposition:
Shared package holds:
- funct3 load encodings: F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU.
- REG_IDX_W=5 and XLEN.
- The wb entry struct {rd, data}.

One sub-module, wb_ld_fifo: synchronous FIFO with async reset, push/pop/full/empty, parameterised depth and width.

Test Plan:
1. Reset, then alu_valid with rd=5, data=0x1234 -> next cycle rd_we=1, writeReg=5, writeData=0x1234; alu_rd=0 -> rd_we=0.
2. ld_issue rd=7, then query_rs1=7 -> stall=1. Response LB addr_lo=2, data=0x0080_0000 -> writeData=0xFFFFFF80. stall drops the cycle after rd_we.
3. LHU addr_lo=2, data=0xBEEF_0000 -> writeData=0x0000BEEF. LH on the same word -> 0xFFFFBEEF. funct3=111 -> full word.
4. alu_valid held high 4 cycles while 3 responses arrive -> ready falls after 2 accepted. Loads write back in order once ALU idles; no response is lost.
5. ld_issue rd=9 and a rd=9 load writeback on the same edge -> pending[9] stays 1.
6. Assert rst with 2 FIFO entries and pending bits set -> outputs 0 immediately, stall=0, later responses are not written from stale state.
